// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and constants for the instruction-cache fill controller
package icache_pkg;

  localparam int ICACHE_IDX_W = 5;
  localparam int ICACHE_TAG_W = 8;
  localparam int ICACHE_BLK_W = 13;

  // Storage width for memory transaction tags. MEM_TAG_W must not exceed this.
  localparam int MSHR_MTAG_W  = 8;

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_LOAD = 2'd1
  } bus_cmd_t;

  typedef enum logic [1:0] {
    MSHR_INVALID    = 2'd0,
    MSHR_WAIT_ISSUE = 2'd1,
    MSHR_WAIT_DATA  = 2'd2
  } mshr_state_t;

  typedef struct packed {
    mshr_state_t             state;
    logic [ICACHE_BLK_W-1:0] blk;
    logic [MSHR_MTAG_W-1:0]  mtag;
  } mshr_entry_t;

  // Block number to block-aligned byte address on the memory bus.
  function automatic logic [31:0] blk_addr(input logic [ICACHE_BLK_W-1:0] blk);
    return {16'b0, blk, 3'b0};
  endfunction

endpackage

// File: rtl/icache_fill_ctrl_prio_pick.sv
// rtl/icache_fill_ctrl_prio_pick.sv - lowest-index one-hot picker
module prio_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         any_o
);

  // Two's-complement trick isolates the lowest set request bit.
  assign gnt_o = req_i & (~req_i + {{(N-1){1'b0}}, 1'b1});
  assign any_o = |req_i;

endmodule

// File: rtl/icache_fill_ctrl.sv
// rtl/icache_fill_ctrl.sv - icache miss/line-fill controller with MSHR table; optional ICACHE_PREFETCH_NEXT_EN
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter int MSHR_DEPTH = 4,
  parameter int MEM_TAG_W  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic [31:0]             req_addr,
  input  logic                    rd_valid,
  output logic [1:0]              proc2mem_command,
  output logic [31:0]             proc2mem_addr,
  input  logic [MEM_TAG_W-1:0]    mem2proc_response,
  input  logic [63:0]             mem2proc_data,
  input  logic [MEM_TAG_W-1:0]    mem2proc_tag,
  output logic                    wr_en,
  output logic [ICACHE_IDX_W-1:0] wr_idx,
  output logic [ICACHE_TAG_W-1:0] wr_tag,
  output logic [63:0]             wr_data,
  output logic                    mshr_full
);

  mshr_entry_t mshr_q [MSHR_DEPTH];
  mshr_entry_t mshr_d [MSHR_DEPTH];

  logic [ICACHE_BLK_W-1:0] req_blk;
  logic                    miss;
  logic                    alloc_en;
  logic                    accept;
  logic                    full_d;
  logic [MSHR_DEPTH-1:0]   free_vec;
  logic [MSHR_DEPTH-1:0]   issue_vec;
  logic [MSHR_DEPTH-1:0]   match_vec;
  logic [MSHR_DEPTH-1:0]   fill_vec;
  logic [MSHR_DEPTH-1:0]   alloc_oh;
  logic [MSHR_DEPTH-1:0]   issue_oh;
  logic [MSHR_DEPTH-1:0]   pf_oh;
  logic                    free_any;
  logic                    issue_any;
  logic [ICACHE_BLK_W-1:0] fill_blk;
  logic [ICACHE_BLK_W-1:0] issue_blk;
  logic [ICACHE_BLK_W-1:0] pf_blk;
  logic                    unused_addr;

  assign req_blk     = req_addr[15:3];
  assign unused_addr = ^{req_addr[31:16], req_addr[2:0]};
  assign miss        = req_valid && !rd_valid;
  assign accept      = mem2proc_response != '0;

  // Per-entry status vectors; entries being filled this cycle still count as matches.
  always_comb begin
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      free_vec[i]  = mshr_q[i].state == MSHR_INVALID;
      issue_vec[i] = mshr_q[i].state == MSHR_WAIT_ISSUE;
      match_vec[i] = (mshr_q[i].state != MSHR_INVALID) && (mshr_q[i].blk == req_blk);
      fill_vec[i]  = (mem2proc_tag != '0) && (mshr_q[i].state == MSHR_WAIT_DATA) &&
                     (mshr_q[i].mtag == MSHR_MTAG_W'(mem2proc_tag));
    end
  end

  prio_pick #(.N(MSHR_DEPTH)) u_pick_free (
    .req_i (free_vec),
    .gnt_o (alloc_oh),
    .any_o (free_any)
  );

  prio_pick #(.N(MSHR_DEPTH)) u_pick_issue (
    .req_i (issue_vec),
    .gnt_o (issue_oh),
    .any_o (issue_any)
  );

  assign alloc_en = miss && !(|match_vec) && free_any;

`ifdef ICACHE_PREFETCH_NEXT_EN
  logic [MSHR_DEPTH-1:0] pf_gnt;
  logic [MSHR_DEPTH-1:0] pf_match_vec;
  logic                  pf_free_any;

  // 13-bit wrap lets the idx carry roll into the tag naturally.
  assign pf_blk = req_blk + ICACHE_BLK_W'(1);

  prio_pick #(.N(MSHR_DEPTH)) u_pick_pf (
    .req_i (free_vec & ~alloc_oh),
    .gnt_o (pf_gnt),
    .any_o (pf_free_any)
  );

  // Next-block pending check against the same occupied entries as the demand dedup.
  always_comb begin
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      pf_match_vec[i] = (mshr_q[i].state != MSHR_INVALID) && (mshr_q[i].blk == pf_blk);
    end
  end

  assign pf_oh = (alloc_en && pf_free_any && !(|pf_match_vec)) ? pf_gnt : '0;
`else
  assign pf_blk = '0;
  assign pf_oh  = '0;
`endif

  // Next-state: fill, issue acceptance and allocation act on disjoint entries.
  always_comb begin
    full_d = 1'b1;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      mshr_d[i] = mshr_q[i];
      if (fill_vec[i]) begin
        mshr_d[i].state = MSHR_INVALID;
      end
      if (issue_oh[i] && accept) begin
        mshr_d[i].state = MSHR_WAIT_DATA;
        mshr_d[i].mtag  = MSHR_MTAG_W'(mem2proc_response);
      end
      if (alloc_en && alloc_oh[i]) begin
        mshr_d[i].state = MSHR_WAIT_ISSUE;
        mshr_d[i].blk   = req_blk;
      end
      if (pf_oh[i]) begin
        mshr_d[i].state = MSHR_WAIT_ISSUE;
        mshr_d[i].blk   = pf_blk;
      end
      if (mshr_d[i].state == MSHR_INVALID) begin
        full_d = 1'b0;
      end
    end
  end

  // Block of the entry being filled (at most one matches a given tag).
  always_comb begin
    fill_blk = '0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (fill_vec[i]) begin
        fill_blk = fill_blk | mshr_q[i].blk;
      end
    end
  end

  // Memory command driven from registered state of the selected issue entry.
  always_comb begin
    issue_blk = '0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (issue_oh[i]) begin
        issue_blk = issue_blk | mshr_q[i].blk;
      end
    end
    proc2mem_command = issue_any ? BUS_LOAD : BUS_NONE;
    proc2mem_addr    = issue_any ? blk_addr(issue_blk) : 32'd0;
  end

  // Entry table, store write port and full flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        mshr_q[i] <= '0;
      end
      wr_en     <= 1'b0;
      wr_idx    <= '0;
      wr_tag    <= '0;
      wr_data   <= '0;
      mshr_full <= 1'b0;
    end else begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        mshr_q[i] <= mshr_d[i];
      end
      wr_en <= |fill_vec;
      if (|fill_vec) begin
        wr_idx  <= fill_blk[ICACHE_IDX_W-1:0];
        wr_tag  <= fill_blk[ICACHE_BLK_W-1:ICACHE_IDX_W];
        wr_data <= mem2proc_data;
      end
      mshr_full <= full_d;
    end
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb/tb_icache_fill_ctrl.sv - scoreboard bench for icache_fill_ctrl
module tb_icache_fill_ctrl;

  localparam int D  = 4;
  localparam int TW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [31:0]   req_addr;
  logic          rd_valid;
  logic [1:0]    proc2mem_command;
  logic [31:0]   proc2mem_addr;
  logic [TW-1:0] mem2proc_response;
  logic [63:0]   mem2proc_data;
  logic [TW-1:0] mem2proc_tag;
  logic          wr_en;
  logic [4:0]    wr_idx;
  logic [7:0]    wr_tag;
  logic [63:0]   wr_data;
  logic          mshr_full;

  icache_fill_ctrl #(.MSHR_DEPTH(D), .MEM_TAG_W(TW)) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_addr          (req_addr),
    .rd_valid          (rd_valid),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .wr_en             (wr_en),
    .wr_idx            (wr_idx),
    .wr_tag            (wr_tag),
    .wr_data           (wr_data),
    .mshr_full         (mshr_full)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  bit mon_en   = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic        full;
  } cyc_exp_t;

  typedef struct {
    int          cyc;
    logic [4:0]  idx;
    logic [7:0]  tag;
    logic [63:0] data;
  } wr_exp_t;

  cyc_exp_t cyc_q[$];
  wr_exp_t  wr_q[$];

  // Reference: slot kind 0 = free, 1 = needs issue, 2 = awaiting data
  int m_kind [D];
  int m_blk  [D];
  int m_tag  [D];

  int pool [6] = '{32'h0010, 32'h0011, 32'h0247, 32'h1FFF, 32'h0020, 32'h0555};

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endfunction

  function automatic int first_kind(input int k, input int from);
    for (int i = from; i < D; i++) if (m_kind[i] == k) return i;
    return -1;
  endfunction

  function automatic bit pending(input int b);
    for (int i = 0; i < D; i++) if (m_kind[i] != 0 && m_blk[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int fresh_tag();
    int t;
    bit used;
    for (int tries = 0; tries < 64; tries++) begin
      t = int'($urandom_range(1, (1 << TW) - 1));
      used = 1'b0;
      for (int i = 0; i < D; i++) if (m_kind[i] == 2 && m_tag[i] == t) used = 1'b1;
      if (!used) return t;
    end
    return 0;
  endfunction

  task automatic step(input bit rv, input logic [31:0] a, input bit hit,
                      input int resp, input int tg, input logic [63:0] d);
    cyc_exp_t ce;
    wr_exp_t  we;
    int iss, fr, b;
    int nk [D];
    int nb [D];
    int nt [D];
    iss      = first_kind(1, 0);
    ce.cyc   = cyc_n;
    ce.cmd   = (iss >= 0) ? 2'd1 : 2'd0;
    ce.addr  = (iss >= 0) ? 32'(m_blk[iss] * 8) : 32'd0;
    ce.full  = (first_kind(0, 0) < 0);
    cyc_q.push_back(ce);

    req_valid         = rv;
    req_addr          = a;
    rd_valid          = hit;
    mem2proc_response = TW'(resp);
    mem2proc_tag      = TW'(tg);
    mem2proc_data     = d;

    nk = m_kind; nb = m_blk; nt = m_tag;
    if (tg != 0) begin
      for (int i = 0; i < D; i++) begin
        if (m_kind[i] == 2 && m_tag[i] == tg) begin
          we.cyc  = cyc_n + 1;
          we.idx  = 5'(m_blk[i] % 32);
          we.tag  = 8'(m_blk[i] / 32);
          we.data = d;
          wr_q.push_back(we);
          nk[i] = 0;
        end
      end
    end
    if (iss >= 0 && resp != 0) begin
      nk[iss] = 2;
      nt[iss] = resp;
    end
    if (rv && !hit) begin
      b = int'(a[15:3]);
      if (!pending(b)) begin
        fr = first_kind(0, 0);
        if (fr >= 0) begin
          nk[fr] = 1;
          nb[fr] = b;
`ifdef ICACHE_PREFETCH_NEXT_EN
          begin
            int fr2, nxt;
            nxt = (b + 1) % 8192;
            fr2 = first_kind(0, fr + 1);
            if (fr2 >= 0 && !pending(nxt)) begin
              nk[fr2] = 1;
              nb[fr2] = nxt;
            end
          end
`endif
        end
      end
    end
    m_kind = nk; m_blk = nb; m_tag = nt;

    @(posedge clock);
    #1;
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'd0, 0, 0, 0, 64'd0);
  endtask

  task automatic do_reset();
    mon_en = 0;
    reset  = 1'b0;
    #1;
    chk("reset_wr_en", 64'(wr_en), 64'd0);
    chk("reset_command", 64'(proc2mem_command), 64'd0);
    chk("reset_addr", 64'(proc2mem_addr), 64'd0);
    chk("reset_full", 64'(mshr_full), 64'd0);
    chk("reset_wr_fields", {wr_data[50:0], wr_idx, wr_tag}, 64'd0);
    for (int i = 0; i < D; i++) begin
      m_kind[i] = 0; m_blk[i] = 0; m_tag[i] = 0;
    end
    cyc_q.delete();
    wr_q.delete();
    req_valid = 0; req_addr = 0; rd_valid = 0;
    mem2proc_response = 0; mem2proc_tag = 0; mem2proc_data = 0;
    @(posedge clock);
    #1;
    cyc_n++;
    reset  = 1'b1;
    mon_en = 1;
  endtask

  task automatic rand_step();
    int resp, tg, r, b, cnt;
    int ds [D];
    logic [31:0] a;
    resp = 0;
    tg   = 0;
    if (first_kind(1, 0) >= 0 && $urandom_range(0, 2) != 0) resp = fresh_tag();
    r = int'($urandom_range(0, 9));
    if (r < 5) begin
      cnt = 0;
      for (int i = 0; i < D; i++) if (m_kind[i] == 2) begin ds[cnt] = m_tag[i]; cnt++; end
      if (cnt > 0) tg = ds[$urandom_range(0, cnt - 1)];
    end else if (r == 5) begin
      tg = fresh_tag();
    end
    if ($urandom_range(0, 3) == 0) b = int'($urandom_range(0, 8191));
    else b = pool[$urandom_range(0, 5)];
    a = {16'($urandom), 13'(b), 3'($urandom)};
    step($urandom_range(0, 2) != 0, a, $urandom_range(0, 3) == 0, resp, tg, {$urandom, $urandom});
  endtask

  // Monitor: compares visible outputs against queued expectations each cycle.
  cyc_exp_t mon_ce;
  wr_exp_t  mon_we;
  bit       mon_exp_wr;
  always @(negedge clock) begin
    if (mon_en) begin
      if (cyc_q.size() > 0 && cyc_q[0].cyc == cyc_n) begin
        mon_ce = cyc_q.pop_front();
        chk("proc2mem_command", 64'(proc2mem_command), 64'(mon_ce.cmd));
        if (mon_ce.cmd == 2'd1) chk("proc2mem_addr", 64'(proc2mem_addr), 64'(mon_ce.addr));
        chk("mshr_full", 64'(mshr_full), 64'(mon_ce.full));
      end
      mon_exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc == cyc_n);
      chk("wr_en", 64'(wr_en), 64'(mon_exp_wr));
      if (mon_exp_wr) begin
        mon_we = wr_q.pop_front();
        if (wr_en) begin
          chk("wr_idx", 64'(wr_idx), 64'(mon_we.idx));
          chk("wr_tag", 64'(wr_tag), 64'(mon_we.tag));
          chk("wr_data", wr_data, mon_we.data);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    req_valid = 0; req_addr = 0; rd_valid = 0;
    mem2proc_response = 0; mem2proc_tag = 0; mem2proc_data = 0;
    @(posedge clock);
    #1;
    do_reset();

    // Single miss, response, fill with known data
    step(1, 32'h0000_1238, 0, 0, 0, 64'd0);
    step(0, 32'd0, 0, 5, 0, 64'd0);
    idle(3);
    step(0, 32'd0, 0, 0, 5, 64'hDEADBEEF_CAFEF00D);
    idle(2);

    // Response retry then acceptance
    step(1, 32'h0000_4000, 0, 0, 0, 64'd0);
    step(0, 32'd0, 0, 0, 0, 64'd0);
    step(0, 32'd0, 0, 0, 0, 64'd0);
    step(0, 32'd0, 0, 0, 0, 64'd0);
    step(0, 32'd0, 0, 2, 0, 64'd0);
    idle(1);
    step(0, 32'd0, 0, 0, 2, 64'h1111_2222_3333_4444);
    idle(2);

    // Dedup on repeated miss, then fill the table
    for (int i = 0; i < 5; i++) step(1, 32'h0000_0100, 0, 0, 0, 64'd0);
    step(1, 32'h0000_0200, 0, 0, 0, 64'd0);
    step(1, 32'h0000_0300, 0, 0, 0, 64'd0);
    step(1, 32'h0000_0400, 0, 0, 0, 64'd0);
    step(1, 32'h0000_0500, 0, 0, 0, 64'd0);
    step(0, 32'd0, 0, 0, 0, 64'd0);

    // Simultaneous fill and miss; fill and miss to the same block
    do_reset();
    step(1, 32'h0000_0080, 0, 0, 0, 64'd0);
    step(0, 32'd0, 0, 1, 0, 64'd0);
    step(1, 32'h0000_0088, 0, 0, 1, 64'hAAAA_0000_BBBB_0001);
    step(0, 32'd0, 0, 2, 0, 64'd0);
    step(1, 32'h0000_0088, 0, 0, 2, 64'hAAAA_0000_BBBB_0002);
    idle(2);

    // Reset with two entries awaiting data; stale tag afterwards is ignored
    do_reset();
    step(1, 32'h0000_1000, 0, 0, 0, 64'd0);
    step(1, 32'h0000_2000, 0, 3, 0, 64'd0);
    step(0, 32'd0, 0, 4, 0, 64'd0);
    do_reset();
    step(0, 32'd0, 0, 0, 3, 64'h5555_6666_7777_8888);
    idle(2);

    // Wrap-around block (next-block prefetch target wraps to 0)
    step(1, 32'h0000_FFF8, 0, 0, 0, 64'd0);
    step(0, 32'd0, 0, 6, 0, 64'd0);
    step(0, 32'd0, 0, 7, 0, 64'd0);
    step(0, 32'd0, 0, 0, 6, 64'h0123_4567_89AB_CDEF);
    step(0, 32'd0, 0, 0, 7, 64'hFEDC_BA98_7654_3210);
    idle(2);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else rand_step();
    end
    idle(1);

    @(negedge clock);
    #1;
    chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    chk("cycle_queue_drained", 64'(cyc_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
